// File: rtl/map_sched_pkg.sv
// Shared types and constants for the map iteration scheduler.
package map_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SUM_W   = 11;
  localparam logic [7:0]  SAT_MAX = 8'hFF;

endpackage

// File: rtl/map_step.sv
// One step of the nonlinear map: nxt = A/4 + drive + (A/8)^2.
// MAP_SAT_EN: saturate the 11-bit sum at 255 instead of wrapping mod 256.
module map_step
  import map_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] drive,
  output logic [DATA_W-1:0] nxt
);

  logic [4:0]       a_div8;
  logic [9:0]       sq;
  logic [SUM_W-1:0] sum;

  assign a_div8 = a[DATA_W-1:3];
  assign sq     = {5'b0, a_div8} * {5'b0, a_div8};
  assign sum    = SUM_W'(a[DATA_W-1:2]) + SUM_W'(drive) + SUM_W'(sq);

`ifdef MAP_SAT_EN
  assign nxt = (sum > SUM_W'(SAT_MAX)) ? SAT_MAX : sum[DATA_W-1:0];
`else
  assign nxt = sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/map_iter_sched.sv
// Round-robin scheduler running iteration jobs from NREQ requesters on one map_step.
// The saturating build is selected with MAP_SAT_EN (handled inside map_step).
module map_iter_sched #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8,
  parameter int ITER_W = 4,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_seed,
  input  logic [NREQ*DATA_W-1:0]   req_drive,
  input  logic [NREQ*ITER_W-1:0]   req_iters,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_value,
  output logic                     rsp_fixed,
  output logic                     busy
);
  import map_sched_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] drive_q;
  logic [ITER_W-1:0] count;
  logic [ID_W-1:0]   ptr;
  logic [DATA_W-1:0] nxt;

  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              accept;
  logic [DATA_W-1:0] seed_g;
  logic [DATA_W-1:0] drive_g;
  logic [ITER_W-1:0] iters_g;

  map_step u_step (
    .a     (a_q),
    .drive (drive_q),
    .nxt   (nxt)
  );

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found)
      req_ready[grant] = 1'b1;
  end

  assign accept  = (state == IDLE) && found;
  assign seed_g  = req_seed[grant*DATA_W +: DATA_W];
  assign drive_g = req_drive[grant*DATA_W +: DATA_W];
  assign iters_g = req_iters[grant*ITER_W +: ITER_W];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      drive_q   <= '0;
      count     <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_value <= '0;
      rsp_fixed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= seed_g;
            drive_q <= drive_g;
            count   <= iters_g;
            rsp_id  <= grant;
            ptr     <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + ID_W'(1);
            if (iters_g == '0) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_value <= seed_g;
              rsp_fixed <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // Fixed point wins over count expiry; A and count stay put.
          if (nxt == a_q) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_value <= a_q;
            rsp_fixed <= 1'b1;
          end else begin
            a_q   <= nxt;
            count <= count - ITER_W'(1);
            if (count == ITER_W'(1)) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_value <= nxt;
              rsp_fixed <= 1'b0;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_iter_sched.sv
// Directed, self-checking bench for map_iter_sched (expects 255 on saturation under MAP_SAT_EN).
module tb_map_iter_sched;

  localparam int NREQ   = 2;
  localparam int DATA_W = 8;
  localparam int ITER_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_seed;
  logic [NREQ*DATA_W-1:0] req_drive;
  logic [NREQ*ITER_W-1:0] req_iters;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [0:0]             rsp_id;
  logic [DATA_W-1:0]      rsp_value;
  logic                   rsp_fixed;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  map_iter_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .ITER_W(ITER_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_seed  (req_seed),
    .req_drive (req_drive),
    .req_iters (req_iters),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_value (rsp_value),
    .rsp_fixed (rsp_fixed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int r, input logic [7:0] seed, input logic [7:0] drv,
                      input logic [3:0] it);
    req_seed[r*DATA_W +: DATA_W]  = seed;
    req_drive[r*DATA_W +: DATA_W] = drv;
    req_iters[r*ITER_W +: ITER_W] = it;
  endtask

  // Issue one job on requester r and check result and latency (cycles after the grant cycle).
  task automatic run_job(input string tag, input int r, input logic [7:0] seed,
                         input logic [7:0] drv, input logic [3:0] it,
                         input logic [7:0] ev, input logic ef, input int el);
    int n;
    int lat;
    load(r, seed, drv, it);
    req_valid[r] = 1'b1;
    n = 0;
    #1;
    while (!req_ready[r] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_grant"}, req_ready[r], 1);
    @(negedge clk);
    req_valid[r] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, el);
    check({tag, "_value"}, rsp_value, ev);
    check({tag, "_fixed"}, rsp_fixed, ef);
    check({tag, "_id"}, rsp_id, r);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_released"}, rsp_valid, 0);
  endtask

  initial begin
    int got;
    int seen;
    logic [0:0] exp_id;

    reset = 1'b1;
    req_valid = '0;
    req_seed = '0;
    req_drive = '0;
    req_iters = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_value", rsp_value, 0);
    check("rst_id", rsp_id, 0);
    check("rst_fixed", rsp_fixed, 0);
    check("rst_ready", req_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    run_job("step1", 0, 8'd64, 8'd0, 4'd1, 8'd80, 1'b0, 2);
    run_job("step2", 0, 8'd64, 8'd0, 4'd2, 8'd120, 1'b0, 3);
    run_job("fix3", 0, 8'd0, 8'd3, 4'd5, 8'd3, 1'b1, 3);
    run_job("fix0", 1, 8'd0, 8'd0, 4'd5, 8'd0, 1'b1, 2);
`ifdef MAP_SAT_EN
    run_job("sat", 0, 8'd255, 8'd200, 4'd1, 8'd255, 1'b0, 2);
`else
    run_job("wrap", 0, 8'd255, 8'd200, 4'd1, 8'd200, 1'b0, 2);
`endif

    // Backpressure on a zero-iteration job while requester 1 waits.
    load(0, 8'h5A, 8'd9, 4'd0);
    req_valid[0] = 1'b1;
    #1;
    check("bp_grant", req_ready, 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    load(1, 8'd1, 8'd1, 4'd1);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_value", rsp_value, 8'h5A);
      check("bp_busy", busy, 1);
      check("bp_no_grant", req_ready, 0);
      @(negedge clk);
    end
    check("bp_fixed", rsp_fixed, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_next_grant", req_ready, 2);
    req_valid[1] = 1'b0;
    #1;
    check("bp_withdraw", req_ready, 0);
    check("bp_idle", busy, 0);

    // Both requesters valid straight out of reset; responses must alternate 0,1,0,1.
    @(negedge clk);
    reset = 1'b1;
    load(0, 8'd64, 8'd0, 4'd1);
    load(1, 8'd0, 8'd3, 4'd1);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got = 0;
    exp_id = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      check("arb_onehot", ($countones(req_ready) <= 1), 1);
      if (rsp_valid && got < 4) begin
        check("arb_id", rsp_id, exp_id);
        check("arb_value", rsp_value, (exp_id == 1'b0) ? 80 : 3);
        exp_id = ~exp_id;
        got++;
      end
      @(negedge clk);
    end
    check("arb_count", got, 4);
    req_valid = '0;
    rsp_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset during a long run aborts the job without a response.
    load(1, 8'd100, 8'd7, 4'd15);
    req_valid[1] = 1'b1;
    #1;
    check("mid_grant", req_ready, 2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_no_rsp", seen, 0);
    run_job("after_rst", 0, 8'd64, 8'd0, 4'd2, 8'd120, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/map_iter_sched.md
Name: map_iter_sched

Overview:
- Shared-resource scheduler for the 8-bit nonlinear map datapath: next = A/4 + drive + (A/8)*(A/8).
- Accepts iteration jobs from NREQ requesters and arbitrates them round-robin onto one map_step instance.
- Runs each job for a programmed iteration count or until a fixed point, then returns the result over a valid/ready response port.
- Sits between host-side job sources (switch/GPIO capture logic) and the display/GPIO output registers.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DATA_W, 8, map state width; the map is defined only for 8.
- ITER_W, 4, width of the per-job iteration count (max 15 steps).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  job request per requester
- req_ready  out  NREQ  grant/accept strobe per requester
- req_seed  in  NREQ*DATA_W  initial A, packed, requester i at [i*8 +: 8]
- req_drive  in  NREQ*DATA_W  constant additive term (ui_in role), packed
- req_iters  in  NREQ*ITER_W  max iteration count, packed
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NREQ) (min 1)  index of the requester the result belongs to
- rsp_value  out  DATA_W  final A
- rsp_fixed  out  1  job ended early on a fixed point (next == A)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; A, count, drive, rsp_id, rsp_value, rsp_fixed = 0; rsp_valid = 0; req_ready = 0; round-robin pointer points at requester 0.
- Reset mid-operation aborts the job. No response is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant goes to the first asserted req_valid, searching from the pointer upward with wrap-around.
  - req_ready[g] = 1 for that cycle only. This is combinational from the state, the pointer and req_valid.
  - Accept = req_valid[g] & req_ready[g].
  - On accept: A <= seed[g], drive <= drive[g], count <= iters[g], rsp_id <= g, pointer <= g+1 mod NREQ.
  - If iters[g] == 0: go to DONE with rsp_value = seed and rsp_fixed = 0. Otherwise go to RUN.
- RUN: one map step per cycle.
  - Compute nxt = map_step(A, drive).
  - If nxt == A: go to DONE with rsp_fixed = 1. A and count are unchanged.
  - Else: A <= nxt and count <= count-1. When count == 1, go to DONE with rsp_fixed = 0.
  - The fixed-point check takes precedence over count expiry in the same cycle.
- DONE:
  - rsp_valid = 1 and rsp_value = A.
  - All response outputs hold stable until rsp_ready; then go to IDLE.
  - A requester cannot be re-granted in the same cycle as the handshake; the earliest new grant is the next cycle.
- Latency: accept at cycle t gives rsp_valid at t+iters+1 without an early exit. A fixed point detected at RUN step k gives rsp_valid at t+k+1.
- Arithmetic:
  - A>>2 gives 6 bits. (A>>3)^2 gives at most 961, so 10 bits.
  - The sum is formed at 11 bits and truncated to 8 bits (mod 256).
- req_seed, req_drive and req_iters are sampled only on accept. Requesters must hold them stable while valid and not ready.
- req_valid deasserting before grant is legal and is treated as a withdrawn request.

Optional Feature:
- Macro: MAP_SAT_EN.
- Defined: the 11-bit sum saturates to 255 instead of wrapping.
- Undefined: mod-256 wrap.
- Fixed-point detection and all other behaviour are identical in both builds.

Decomposition:
- Package map_sched_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the DATA_W=8 constant;
  - the SUM_W=11 constant;
  - the saturation limit constant 8'hFF.
- Sub-module map_step: purely combinational nxt from (a, drive). It contains the MAP_SAT_EN branch.
- Arbiter and FSM stay in map_iter_sched.

Test Plan:
- Single step:
  - req0: seed=64, drive=0, iters=1 -> rsp_value=80, rsp_fixed=0, rsp_id=0, rsp_valid 2 cycles after accept.
  - Same job with iters=2 -> rsp_value=120.
- Fixed point:
  - seed=0, drive=3, iters=5 -> step 1 gives A=3; step 2 sees nxt==3 -> rsp_value=3, rsp_fixed=1, rsp_valid at accept+3.
  - seed=0, drive=0 -> rsp_value=0, rsp_fixed=1 after 1 step.
- Wrap vs saturate:
  - seed=255, drive=200, iters=1 -> rsp_value=200 without MAP_SAT_EN.
  - Same job -> rsp_value=255 with MAP_SAT_EN.
- Arbitration:
  - Both requesters valid from the first cycle after reset -> req0 served first, then req1.
  - After that, with both held valid, grants alternate 0,1,0 and rsp_id follows the same sequence.
- Backpressure and zero iterations:
  - iters=0, seed=0x5A, rsp_ready held low 10 cycles -> rsp_valid held with rsp_value=0x5A, busy=1.
  - No new req_ready is issued until rsp_ready rises.
- Reset mid-run:
  - Assert reset during RUN of an iters=15 job -> next cycle state IDLE, rsp_valid=0, busy=0, no response emitted.
  - A new job afterwards completes normally.
